// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS core's multiply/divide unit.
// Operation and FSM encodings plus the HI/LO read-select constants used by the controller.
package mips_pkg;

  typedef enum logic [1:0] {
    MULT  = 2'd0,
    MULTU = 2'd1,
    DIV   = 2'd2,
    DIVU  = 2'd3
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE,
    PREP,
    CALC,
    FIX
  } muldiv_state_t;

  localparam logic [1:0] HLSEL_NONE = 2'b00;
  localparam logic [1:0] HLSEL_HI   = 2'b01;
  localparam logic [1:0] HLSEL_LO   = 2'b10;

  function automatic logic opIsDiv(input muldiv_op_t o);
    return (o == DIV) || (o == DIVU);
  endfunction

  function automatic logic opIsSigned(input muldiv_op_t o);
    return (o == MULT) || (o == DIV);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration of the multiply/divide datapath (purely combinational).
// acc holds {HI-part, LO-part}: {partial product, multiplier} or {remainder, dividend/quotient}.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic                 isDiv,
  input  logic [2*WIDTH-1:0]   acc,
  input  logic [WIDTH-1:0]     operand,
  output logic [2*WIDTH-1:0]   accNext
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   remTop;
  logic [WIDTH+1:0] diff;

  // NOTE: every output of a combinational block gets a default first so no path infers a latch.
  always_comb begin
    sum     = '0;
    remTop  = '0;
    diff    = '0;
    accNext = acc;
    if (isDiv) begin
      // Shifted remainder needs one extra bit before the trial subtract.
      remTop = acc[2*WIDTH-1:WIDTH-1];
      diff   = {1'b0, remTop} - {2'b00, operand};
      if (diff[WIDTH+1]) begin
        accNext = {remTop[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end else begin
        accNext = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end
    end else begin
      sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
      accNext = {sum, acc[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_hilo_unit.sv
// Iterative mult/div engine with HI/LO registers: FSM, step counter, sign fix and HI/LO read port.
// Build option: define MTHILO_EN to let mthi/mtlo write HI/LO from wdata while idle.
module muldiv_hilo_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  input  logic [1:0]       mfhl,
  output logic [WIDTH-1:0] hl_rdata,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata
);

  localparam int CW = $clog2(WIDTH);

  muldiv_state_t        state, stateNext;
  muldiv_op_t           opReg;
  logic [CW-1:0]        cnt;
  logic [WIDTH-1:0]     srcaReg, srcbReg, operand, hi, lo;
  logic [2*WIDTH-1:0]   acc, accNext, prodFix;
  logic                 negLo, negHi, doneReg, isDiv, aNeg, bNeg, mtWriteOk;
  logic [WIDTH-1:0]     aMag, bMag, quoFix, remFix, hiFix, loFix;

  muldiv_step #(.WIDTH(WIDTH)) uStep (
    .isDiv   (isDiv),
    .acc     (acc),
    .operand (operand),
    .accNext (accNext)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:    if (start && !abort) stateNext = PREP;
      PREP:    stateNext = abort ? IDLE : CALC;
      CALC:    if (abort) stateNext = IDLE;
               else if (cnt == CW'(WIDTH - 1)) stateNext = FIX;
      FIX:     stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    isDiv   = opIsDiv(opReg);
    aNeg    = opIsSigned(opReg) && srcaReg[WIDTH-1];
    bNeg    = opIsSigned(opReg) && srcbReg[WIDTH-1];
    aMag    = aNeg ? -srcaReg : srcaReg;
    bMag    = bNeg ? -srcbReg : srcbReg;
    prodFix = negLo ? -acc : acc;
    quoFix  = negLo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    remFix  = negHi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    {hiFix, loFix} = prodFix;
    if (isDiv) begin
      // Divide by zero returns the raw dividend and an all-ones quotient regardless of signs.
      if (srcbReg == '0) {hiFix, loFix} = {srcaReg, {WIDTH{1'b1}}};
      else               {hiFix, loFix} = {remFix, quoFix};
    end
  end

`ifdef MTHILO_EN
  assign mtWriteOk = (state == IDLE) && !start;
`else
  logic unusedMthilo;
  assign mtWriteOk    = 1'b0;
  assign unusedMthilo = ^{mthi, mtlo, wdata};
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      opReg   <= MULT;
      srcaReg <= '0;
      srcbReg <= '0;
      operand <= '0;
      acc     <= '0;
      cnt     <= '0;
      negLo   <= 1'b0;
      negHi   <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      doneReg <= 1'b0;
    end else begin
      doneReg <= 1'b0;
      unique case (state)
        IDLE: if (start && !abort) begin
          opReg   <= muldiv_op_t'(op);
          srcaReg <= srca;
          srcbReg <= srcb;
        end
        PREP: begin
          acc     <= {{WIDTH{1'b0}}, isDiv ? aMag : bMag};
          operand <= isDiv ? bMag : aMag;
          negLo   <= aNeg ^ bNeg;
          negHi   <= aNeg;
          cnt     <= '0;
        end
        CALC: begin
          acc <= accNext;
          cnt <= cnt + CW'(1);
        end
        FIX: if (!abort) begin
          hi      <= hiFix;
          lo      <= loFix;
          doneReg <= 1'b1;
        end
        default: ;
      endcase
      if (mtWriteOk && mthi) hi <= wdata;
      if (mtWriteOk && mtlo) lo <= wdata;
    end
  end

  assign busy = (state != IDLE);
  assign done = doneReg;

  always_comb begin
    unique case (mfhl)
      HLSEL_HI: hl_rdata = hi;
      HLSEL_LO: hl_rdata = lo;
      default:  hl_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Self-checking bench for muldiv_hilo_unit: directed and random ops against an arithmetic model.
// Expectations for mthi/mtlo follow whether MTHILO_EN is defined for the build.
module tb_muldiv_hilo_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, start, abort, mthi, mtlo, busy, done;
  logic [1:0]   op, mfhl;
  logic [W-1:0] srca, srcb, wdata, hl_rdata;

  int           total = 0;
  int           bad   = 0;
  logic [W-1:0] expHi = '0;
  logic [W-1:0] expLo = '0;

  always #5 clk = ~clk;

  muldiv_hilo_unit #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .srca     (srca),
    .srcb     (srcb),
    .abort    (abort),
    .busy     (busy),
    .done     (done),
    .mfhl     (mfhl),
    .hl_rdata (hl_rdata),
    .mthi     (mthi),
    .mtlo     (mtlo),
    .wdata    (wdata)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain arithmetic on 64-bit values; returns {HI, LO}.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, q, r;
    logic [63:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    res = '0;
    case (o)
      2'd0: res = 64'(sa * sb);
      2'd1: res = {32'b0, a} * {32'b0, b};
      2'd2: begin
        if (b == 0) res = {a, 32'hFFFF_FFFF};
        else begin
          q   = sa / sb;
          r   = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == 0) res = {a, 32'hFFFF_FFFF};
        else        res = {a % b, a / b};
      end
    endcase
    return res;
  endfunction

  task automatic checkHl(input string tag);
    logic [W-1:0] h, l;
    mfhl = 2'b01; #1 h = hl_rdata;
    mfhl = 2'b10; #1 l = hl_rdata;
    mfhl = 2'b00;
    check({tag, "_hi"}, h, expHi);
    check({tag, "_lo"}, l, expLo);
  endtask

  task automatic launch(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    start = 1'b1; op = o; srca = a; srcb = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits (bounded) for busy to fall, then checks latency, done pulse and HI/LO.
  task automatic finishOp(input string tag, input logic [1:0] o, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int expLat);
    int cycles = 0;
    while (busy === 1'b1 && cycles < 100) begin
      @(negedge clk);
      cycles++;
    end
    check({tag, "_lat"}, cycles, expLat);
    check({tag, "_done"}, done, 1'b1);
    {expHi, expLo} = model(o, a, b);
    checkHl(tag);
    @(negedge clk);
    check({tag, "_done1"}, done, 1'b0);
  endtask

  logic [1:0]   dOp [5] = '{2'd1, 2'd0, 2'd2, 2'd3, 2'd2};
  logic [W-1:0] dA  [5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'h7, 32'h8000_0000};
  logic [W-1:0] dB  [5] = '{32'h2, 32'h5, 32'h2, 32'h0, 32'hFFFF_FFFF};

  initial begin
    logic [1:0]   ro;
    logic [W-1:0] ra, rb;
    int           cyc;

    reset = 1'b0; start = 1'b0; abort = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    op = 2'd0; srca = '0; srcb = '0; wdata = '0; mfhl = 2'b00;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    checkHl("rst");
    reset = 1'b1;

    for (int i = 0; i < 5; i++) begin
      launch(dOp[i], dA[i], dB[i]);
      finishOp($sformatf("dir%0d", i), dOp[i], dA[i], dB[i], 34);
    end
    mfhl = 2'b11; #1 check("sel_rsvd", hl_rdata, 32'h0);
    mfhl = 2'b00; #1 check("sel_none", hl_rdata, 32'h0);

    for (int i = 0; i < 16; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      if (i % 5 == 0) rb = '0;
      if (i % 4 == 1) rb = 32'($urandom_range(1, 20));
      if (i % 6 == 2) rb = 32'hFFFF_FFFF;
      launch(ro, ra, rb);
      finishOp($sformatf("rnd%0d", i), ro, ra, rb, 34);
    end

    // Abort in CALC step 10: no write, no done.
    launch(2'd3, 32'd100, 32'd7);
    repeat (11) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    checkHl("abort");
    @(negedge clk);
    check("abort_done1", done, 1'b0);

    // Start while busy is ignored.
    launch(2'd3, 32'd100, 32'd7);
    repeat (5) @(negedge clk);
    start = 1'b1; op = 2'd1; srca = 32'd5; srcb = 32'd5;
    @(negedge clk);
    start = 1'b0;
    finishOp("busy_start", 2'd3, 32'd100, 32'd7, 28);

    // Abort and start together from idle: start dropped.
    @(negedge clk);
    start = 1'b1; abort = 1'b1; op = 2'd1; srca = 32'd9; srcb = 32'd9;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("abst_busy", busy, 1'b0);
    @(negedge clk);
    check("abst_done", done, 1'b0);
    checkHl("abst");

    // Abort in the FIX cycle suppresses the write.
    launch(2'd1, 32'd3, 32'd4);
    repeat (33) @(negedge clk);
    check("fix_busy", busy, 1'b1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("fixab_busy", busy, 1'b0);
    check("fixab_done", done, 1'b0);
    checkHl("fixab");

    // Reset in CALC step 5 of a MULT.
    launch(2'd0, 32'hFFFF_FFFD, 32'd5);
    repeat (6) @(negedge clk);
    reset = 1'b0;
    #1;
    check("mrst_busy", busy, 1'b0);
    expHi = '0; expLo = '0;
    checkHl("mrst");
    @(negedge clk);
    reset = 1'b1;
    launch(2'd2, 32'hFFFF_FFF9, 32'd2);
    finishOp("post_rst", 2'd2, 32'hFFFF_FFF9, 32'd2, 34);

    // mthi while idle.
    @(negedge clk);
    mthi = 1'b1; wdata = 32'h1234;
    @(negedge clk);
    mthi = 1'b0;
`ifdef MTHILO_EN
    expHi = 32'h1234;
`endif
    checkHl("mthi_idle");

    // mthi in the same cycle as start: start wins, result overwrites anyway.
    @(negedge clk);
    start = 1'b1; op = 2'd1; srca = 32'd6; srcb = 32'd7; mthi = 1'b1; wdata = 32'hABCD;
    @(negedge clk);
    start = 1'b0; mthi = 1'b0;
    // mtlo while busy is ignored.
    mtlo = 1'b1; wdata = 32'hDEAD;
    @(negedge clk);
    mtlo = 1'b0;
    finishOp("mt_busy", 2'd1, 32'd6, 32'd7, 33);

    // mtlo in the done cycle overrides the fresh result.
    launch(2'd1, 32'd11, 32'd13);
    cyc = 0;
    while (busy === 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("ovr_lat", cyc, 34);
    check("ovr_done", done, 1'b1);
    mtlo = 1'b1; wdata = 32'hCAFE;
    @(negedge clk);
    mtlo = 1'b0;
    {expHi, expLo} = model(2'd1, 32'd11, 32'd13);
`ifdef MTHILO_EN
    expLo = 32'hCAFE;
`endif
    checkHl("ovr");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
